// File: rtl/i2s_sync_pkg.sv
// Shared types and widths for the I2S sync-source selector.
package i2s_sync_pkg;
  localparam int POSN_W = 6;
  localparam int QUAL_W = 3;

  typedef enum logic [1:0] {
    ST_INT    = 2'd0,
    ST_TO_EXT = 2'd1,
    ST_EXT    = 2'd2,
    ST_TO_INT = 2'd3
  } sync_state_t;
endpackage

// File: rtl/i2s_sync_select_presence.sv
// External-presence watchdog and frame-start qualifier for the sync selector.
// Module name i2s_presence; present drops after 2^WIDTH-1 gen_en pulses without ext_en.
module i2s_presence
  import i2s_sync_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int QUAL_FRAMES = 2
) (
  input  logic ck,
  input  logic rst_n,
  input  logic gen_en,
  input  logic ext_en,
  input  logic ext_fs,
  input  logic clr,
  output logic present,
  output logic qualified
);
  localparam logic [WIDTH-1:0] S_MAX = '1;

  // Down-counter of gen strobes left before the primary is considered gone;
  // zero (terminal count) means absent, which is also the reset condition.
  logic [WIDTH-1:0]  remain;
  logic [QUAL_W-1:0] qual;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      remain <= '0;
    end else if (ext_en) begin
      remain <= S_MAX;
    end else if (gen_en && (remain != '0)) begin
      remain <= remain - WIDTH'(1);
    end
  end

  assign present = (remain != '0);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      qual <= '0;
    end else if (clr || !present) begin
      qual <= '0;
    end else if (ext_fs && (qual != '1)) begin
      qual <= qual + QUAL_W'(1);
    end
  end

  assign qualified = (qual >= QUAL_W'(QUAL_FRAMES));
endmodule

// File: rtl/i2s_sync_select.sv
// Frame-aligned selection between internal and recovered external I2S bit timing.
// Optional I2S_SYNC_SELECT_FORCE_EN adds force_int to pin the selection to internal.
//
// state     | meaning
// ST_INT    | output follows gen, waiting for a qualified external primary
// ST_TO_EXT | output follows gen, switching at the next ext frame start
// ST_EXT    | output follows ext
// ST_TO_INT | output muted, switching back at the next gen frame start
module i2s_sync_select
  import i2s_sync_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int QUAL_FRAMES = 2
) (
  input  logic              ck,
  input  logic              rst_n,
`ifdef I2S_SYNC_SELECT_FORCE_EN
  input  logic              force_int,
`endif
  input  logic              gen_en,
  input  logic [POSN_W-1:0] gen_posn,
  input  logic              ext_en,
  input  logic [POSN_W-1:0] ext_posn,
  output logic              en,
  output logic [POSN_W-1:0] frame_posn,
  output logic              external,
  output logic              switched
);
  sync_state_t       state_q, state_d;
  logic              force_sel;
  logic              gen_fs, ext_fs;
  logic              present, qualified, clr_qual;
  logic              en_d, switched_d;
  logic [POSN_W-1:0] posn_d;

`ifdef I2S_SYNC_SELECT_FORCE_EN
  assign force_sel = force_int;
`else
  assign force_sel = 1'b0;
`endif

  assign gen_fs = gen_en && (gen_posn == '0);
  assign ext_fs = ext_en && (ext_posn == '0);

  // Qualification restarts on every fallback and whenever internal is forced.
  assign clr_qual = force_sel || ((state_d == ST_TO_INT) && (state_q != ST_TO_INT));

  i2s_presence #(
    .WIDTH      (WIDTH),
    .QUAL_FRAMES(QUAL_FRAMES)
  ) u_presence (
    .ck       (ck),
    .rst_n    (rst_n),
    .gen_en   (gen_en),
    .ext_en   (ext_en),
    .ext_fs   (ext_fs),
    .clr      (clr_qual),
    .present  (present),
    .qualified(qualified)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    en_d       = 1'b0;
    posn_d     = frame_posn;
    switched_d = 1'b0;
    case (state_q)
      ST_INT: begin
        en_d = gen_en;
        if (gen_en) posn_d = gen_posn;
        if (!force_sel && present && qualified) state_d = ST_TO_EXT;
      end
      ST_TO_EXT: begin
        en_d = gen_en;
        if (gen_en) posn_d = gen_posn;
        if (force_sel || !present) begin
          state_d = ST_INT;
        end else if (ext_fs) begin
          en_d       = 1'b1;
          posn_d     = '0;
          state_d    = ST_EXT;
          switched_d = 1'b1;
        end
      end
      ST_EXT: begin
        en_d = ext_en;
        if (ext_en) posn_d = ext_posn;
        if (force_sel || !present) state_d = ST_TO_INT;
      end
      ST_TO_INT: begin
        // Gen wins a tie so a simultaneous pair of frame starts lands in INT.
        if (gen_fs) begin
          en_d       = 1'b1;
          posn_d     = gen_posn;
          state_d    = ST_INT;
          switched_d = 1'b1;
        end else if (ext_fs && !force_sel) begin
          en_d    = 1'b1;
          posn_d  = ext_posn;
          state_d = ST_EXT;
        end
      end
      default: state_d = ST_INT;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      en         <= 1'b0;
      frame_posn <= '0;
      external   <= 1'b0;
      switched   <= 1'b0;
    end else begin
      en         <= en_d;
      frame_posn <= posn_d;
      external   <= (state_d == ST_EXT) || (state_d == ST_TO_INT);
      switched   <= switched_d;
    end
  end
endmodule

// File: tb/tb_i2s_sync_select.sv
// Self-checking bench for i2s_sync_select: reference model plus directed scenarios.
module tb_i2s_sync_select;
  localparam int S_MAX  = 31;
  localparam int QF     = 2;
  localparam int M_INT    = 0;
  localparam int M_TO_EXT = 1;
  localparam int M_EXT    = 2;
  localparam int M_TO_INT = 3;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       force_int = 1'b0;
  logic       gen_en = 1'b0;
  logic [5:0] gen_posn = '0;
  logic       ext_en = 1'b0;
  logic [5:0] ext_posn = '0;
  logic       en;
  logic [5:0] frame_posn;
  logic       external;
  logic       switched;

  int n_cmp = 0;
  int n_bad = 0;

  i2s_sync_select #(.WIDTH(5), .QUAL_FRAMES(QF)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
`ifdef I2S_SYNC_SELECT_FORCE_EN
    .force_int (force_int),
`endif
    .gen_en    (gen_en),
    .gen_posn  (gen_posn),
    .ext_en    (ext_en),
    .ext_posn  (ext_posn),
    .en        (en),
    .frame_posn(frame_posn),
    .external  (external),
    .switched  (switched)
  );

  always #5 ck = ~ck;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: gap counts gen strobes since the last ext strobe.
  int m_gap = S_MAX;
  int m_qual = 0;
  int m_mode = M_INT;
  int x_en = 0, x_posn = 0, x_ext = 0, x_sw = 0;

  always begin
    int g_en, g_p, e_en, e_p, f, nm;
    bit pres, gfs, efs;
    @(posedge ck);
    g_en = int'(gen_en); g_p = int'(gen_posn);
    e_en = int'(ext_en); e_p = int'(ext_posn); f = int'(force_int);
    if (!rst_n) begin
      m_gap = S_MAX; m_qual = 0; m_mode = M_INT;
      x_en = 0; x_posn = 0; x_ext = 0; x_sw = 0;
    end else begin
      pres = (m_gap < S_MAX);
      gfs  = (g_en == 1) && (g_p == 0);
      efs  = (e_en == 1) && (e_p == 0);
      nm = m_mode; x_en = 0; x_sw = 0;
      if (m_mode == M_INT) begin
        x_en = g_en; if (g_en == 1) x_posn = g_p;
        if (f == 0 && pres && m_qual >= QF) nm = M_TO_EXT;
      end else if (m_mode == M_TO_EXT) begin
        x_en = g_en; if (g_en == 1) x_posn = g_p;
        if (f == 1 || !pres) nm = M_INT;
        else if (efs) begin x_en = 1; x_posn = 0; nm = M_EXT; x_sw = 1; end
      end else if (m_mode == M_EXT) begin
        x_en = e_en; if (e_en == 1) x_posn = e_p;
        if (f == 1 || !pres) nm = M_TO_INT;
      end else begin
        if (gfs) begin x_en = 1; x_posn = g_p; nm = M_INT; x_sw = 1; end
        else if (efs && f == 0) begin x_en = 1; x_posn = e_p; nm = M_EXT; end
      end
      if (!pres || f == 1 || (nm == M_TO_INT && m_mode != M_TO_INT)) m_qual = 0;
      else if (efs && m_qual < 7) m_qual++;
      if (e_en == 1) m_gap = 0;
      else if (g_en == 1 && m_gap < S_MAX) m_gap++;
      m_mode = nm;
      x_ext = (nm == M_EXT || nm == M_TO_INT) ? 1 : 0;
    end
    #1;
    chk("en", int'(en), x_en);
    chk("frame_posn", int'(frame_posn), x_posn);
    chk("external", int'(external), x_ext);
    chk("switched", int'(switched), x_sw);
  end

  // Stimulus streams: strobe every 4 clocks, 64 positions per frame.
  int gdiv = 0, ediv = 0, emode = 0, efs_cnt = 0;
  logic [5:0] gp = '0, ep = '0;

  task automatic drive();
    if (gdiv == 0) begin gen_en = 1'b1; gen_posn = gp; gp = gp + 6'd1; end
    else gen_en = 1'b0;
    gdiv = (gdiv + 1) % 4;
    if (emode == 1) begin
      if (ediv == 0) begin ext_en = 1'b1; ext_posn = ep; ep = ep + 6'd1; end
      else ext_en = 1'b0;
      ediv = (ediv + 1) % 4;
    end else if (emode == 2) begin
      ext_en = gen_en;
      if (gen_en) ext_posn = gen_posn;
    end else begin
      ext_en = 1'b0;
    end
    if (ext_en && ext_posn == 6'd0) efs_cnt++;
  endtask

  task automatic tick();
    @(negedge ck);
    drive();
  endtask

  task automatic start_offset_ext();
    ediv = (gdiv + 2) % 4;
    ep = 6'd60;
    efs_cnt = 0;
    emode = 1;
  endtask

  task automatic wait_sw(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (switched) break;
    end
    chk("switch_seen", int'(switched), 1);
  endtask

  task automatic wait_mode(input int m, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_mode == m) break;
      tick();
    end
    chk("mode_reached", m_mode, m);
  endtask

  initial begin
    int sw_cnt, ext_cnt;
    repeat (3) tick();
    chk("rst_en", int'(en), 0);
    chk("rst_posn", int'(frame_posn), 0);
    chk("rst_external", int'(external), 0);
    chk("rst_switched", int'(switched), 0);
    @(negedge ck); rst_n = 1'b1; drive();

    // gen only: outputs mirror gen one clock later
    repeat (300) tick();
    chk("gen_only_external", int'(external), 0);

    // qualification: switch lands on the third ext frame start
    start_offset_ext();
    wait_sw(1500);
    chk("sw_ext_starts", efs_cnt, 3);
    chk("sw_ext_posn", int'(frame_posn), 0);
    chk("sw_ext_external", int'(external), 1);
    chk("sw_ext_en", int'(en), 1);

    // loss in EXT: mute, then back to gen at its frame start
    emode = 0;
    wait_sw(600);
    chk("back_int_posn", int'(frame_posn), 0);
    chk("back_int_external", int'(external), 0);
    chk("back_int_en", int'(en), 1);
    repeat (100) tick();

    // re-qualify, then lose ext and restart it aligned with gen while muted
    start_offset_ext();
    wait_sw(1500);
    chk("requal_starts", efs_cnt, 3);
    emode = 0;
    wait_mode(M_TO_INT, 400);
    emode = 2;
    wait_sw(400);
    chk("tie_posn", int'(frame_posn), 0);
    chk("tie_external", int'(external), 0);

    // loss while waiting in TO_EXT: no switch, gen stream untouched
    wait_mode(M_TO_EXT, 1500);
    emode = 0;
    sw_cnt = 0; ext_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (switched) sw_cnt++;
      if (external) ext_cnt++;
    end
    chk("to_ext_loss_switches", sw_cnt, 0);
    chk("to_ext_loss_external", ext_cnt, 0);

    // reset pulse while in EXT
    start_offset_ext();
    wait_sw(1500);
    repeat (10) tick();
    @(negedge ck); rst_n = 1'b0; drive();
    #1;
    chk("arst_en", int'(en), 0);
    chk("arst_posn", int'(frame_posn), 0);
    chk("arst_external", int'(external), 0);
    chk("arst_switched", int'(switched), 0);
    @(negedge ck); rst_n = 1'b1; drive();
    efs_cnt = 0;
    repeat (100) tick();
    chk("post_rst_external", int'(external), 0);

`ifdef I2S_SYNC_SELECT_FORCE_EN
    wait_sw(1500);
    chk("force_pre_external", int'(external), 1);
    force_int = 1'b1;
    wait_sw(600);
    chk("force_int_posn", int'(frame_posn), 0);
    chk("force_int_external", int'(external), 0);
    repeat (300) tick();
    chk("force_hold_external", int'(external), 0);
    force_int = 1'b0;
    efs_cnt = 0;
    wait_sw(1500);
    chk("force_release_starts", efs_cnt, 3);
    chk("force_release_external", int'(external), 1);
`else
    repeat (200) tick();
`endif

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
